// File: rtl/dunit_reg_dump.sv
// Debug-unit register dump: freezes the pipeline and streams all 32 registers MSB byte first to a UART.
// Optional macro DUNIT_PC_DUMP_EN appends the 4 PC bytes after register 31.
module dunit_reg_dump #(
    parameter int NB_REG  = 32,
    parameter int NB_ADDR = 5,
    parameter int NB_BYTE = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    output logic               o_dunit_clk_en,
    output logic [NB_ADDR-1:0] o_dunit_reg_addr,
    input  logic [NB_REG-1:0]  i_dunit_reg_data,
    input  logic [NB_REG-1:0]  i_pc,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done
);

    localparam int BYTES = NB_REG / NB_BYTE;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
`ifdef DUNIT_PC_DUMP_EN
        PC_LOAD,
`endif
        DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [NB_REG-1:0]  shift_reg;
    logic [CNT_W-1:0]   byte_cnt;
    logic [NB_ADDR-1:0] addr;
    logic               xfer;
    logic               last_byte;
    logic               last_reg;

`ifdef DUNIT_PC_DUMP_EN
    logic               pc_phase;
`else
    logic               unused_pc;
    assign unused_pc = ^i_pc;
`endif

    assign xfer      = (state == SEND) && i_tx_ready;
    assign last_byte = (byte_cnt == CNT_W'(BYTES - 1));
    assign last_reg  = (addr == '1);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (i_start) next_state = LOAD;
            LOAD:    next_state = SEND;
            SEND: begin
                if (xfer && last_byte) begin
`ifdef DUNIT_PC_DUMP_EN
                    if (pc_phase)      next_state = DONE;
                    else if (last_reg) next_state = PC_LOAD;
                    else               next_state = LOAD;
`else
                    if (last_reg) next_state = DONE;
                    else          next_state = LOAD;
`endif
                end
            end
`ifdef DUNIT_PC_DUMP_EN
            PC_LOAD: next_state = SEND;
`endif
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Address is cleared on the final transfer so it already reads 0 in DONE.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            shift_reg <= '0;
            byte_cnt  <= '0;
            addr      <= '0;
`ifdef DUNIT_PC_DUMP_EN
            pc_phase  <= 1'b0;
`endif
        end else begin
            case (state)
                LOAD: begin
                    shift_reg <= i_dunit_reg_data;
                    byte_cnt  <= '0;
                end
`ifdef DUNIT_PC_DUMP_EN
                PC_LOAD: begin
                    shift_reg <= i_pc;
                    byte_cnt  <= '0;
                    pc_phase  <= 1'b1;
                end
`endif
                SEND: begin
                    if (xfer) begin
                        shift_reg <= shift_reg << NB_BYTE;
                        byte_cnt  <= byte_cnt + CNT_W'(1);
                        if (last_byte) begin
`ifdef DUNIT_PC_DUMP_EN
                            if (pc_phase) begin
                                addr     <= '0;
                                pc_phase <= 1'b0;
                            end else if (!last_reg) begin
                                addr <= addr + NB_ADDR'(1);
                            end
`else
                            if (last_reg) addr <= '0;
                            else          addr <= addr + NB_ADDR'(1);
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_busy           = (state != IDLE);
        o_dunit_clk_en   = (state == IDLE) || (state == DONE);
        o_tx_valid       = (state == SEND);
        o_tx_data        = (state == SEND) ? shift_reg[NB_REG-1 -: NB_BYTE] : '0;
        o_done           = (state == DONE);
        o_dunit_reg_addr = addr;
    end

endmodule

// File: tb/tb_dunit_reg_dump.sv
// Bench for dunit_reg_dump: a byte-stream model of the dump checked on every cycle plus directed scenarios.
module tb_dunit_reg_dump;

    localparam int NB_REG  = 32;
    localparam int NB_ADDR = 5;
    localparam int NB_BYTE = 8;
`ifdef DUNIT_PC_DUMP_EN
    localparam int TOTAL = 132;
`else
    localparam int TOTAL = 128;
`endif
    localparam logic [31:0] PC_VALUE = 32'h0000_0040;

    logic               i_clk;
    logic               i_reset;
    logic               i_start;
    logic               o_dunit_clk_en;
    logic [NB_ADDR-1:0] o_dunit_reg_addr;
    logic [NB_REG-1:0]  i_dunit_reg_data;
    logic [NB_REG-1:0]  i_pc;
    logic [NB_BYTE-1:0] o_tx_data;
    logic               o_tx_valid;
    logic               i_tx_ready;
    logic               o_busy;
    logic               o_done;

    int         check_count = 0;
    int         pass_count  = 0;
    int         done_count  = 0;
    int         byte_idx    = 0;
    logic [7:0] rx[$];
    bit         rand_en     = 0;
    bit         prev_stall  = 0;
    bit         prev_last   = 0;
    logic [7:0] prev_data   = '0;

    dunit_reg_dump #(.NB_REG(NB_REG), .NB_ADDR(NB_ADDR), .NB_BYTE(NB_BYTE)) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_start          (i_start),
        .o_dunit_clk_en   (o_dunit_clk_en),
        .o_dunit_reg_addr (o_dunit_reg_addr),
        .i_dunit_reg_data (i_dunit_reg_data),
        .i_pc             (i_pc),
        .o_tx_data        (o_tx_data),
        .o_tx_valid       (o_tx_valid),
        .i_tx_ready       (i_tx_ready),
        .o_busy           (o_busy),
        .o_done           (o_done)
    );

    // Register file model: r[k] = DEADBEEF + k, read combinationally.
    assign i_dunit_reg_data = 32'hDEAD_BEEF + {27'd0, o_dunit_reg_addr};

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] expected_byte(input int idx);
        logic [31:0] word;
        if (idx < 128) word = 32'hDEAD_BEEF + 32'(idx / 4);
        else           word = PC_VALUE;
        return 8'((word >> (24 - 8 * (idx % 4))) & 32'hFF);
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic apply_stimulus();
        @(posedge i_clk); #1 i_start = 1'b1;
        @(posedge i_clk); #1 i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start_count;
        bit seen;
        start_count = done_count;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge i_clk);
            if (done_count > start_count) begin
                seen = 1;
                break;
            end
        end
        check_output("done_seen", 32'(seen), 1);
    endtask

    task automatic wait_bytes(input int count, input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge i_clk);
            if (rx.size() >= count) begin
                seen = 1;
                break;
            end
        end
        check_output("bytes_seen", 32'(seen), 1);
    endtask

    // Random ready only while a scenario asks for it.
    initial forever begin
        @(posedge i_clk);
        #1;
        if (rand_en) i_tx_ready = 1'($urandom_range(0, 1));
    end

    // Every-cycle comparison against the byte-stream model and the handshake rules.
    initial forever begin
        @(negedge i_clk);
        if (i_reset) begin
            byte_idx   = 0;
            prev_stall = 0;
            prev_last  = 0;
        end else begin
            check_output("clk_en", 32'(o_dunit_clk_en), 32'(!o_busy || o_done));
            if (!o_busy) check_output("idle_valid", 32'(o_tx_valid), 0);
            if (prev_stall) begin
                check_output("stall_valid", 32'(o_tx_valid), 1);
                check_output("stall_data", 32'(o_tx_data), 32'(prev_data));
            end
            if (prev_last) check_output("bubble", 32'(o_tx_valid), 0);
            prev_last = 0;
            if (o_tx_valid && i_tx_ready) begin
                if (byte_idx >= TOTAL) begin
                    check_output("overrun", 32'(byte_idx), 32'(TOTAL - 1));
                end else begin
                    check_output("tx_byte", 32'(o_tx_data), 32'(expected_byte(byte_idx)));
                    if (byte_idx < 128) check_output("reg_addr", 32'(o_dunit_reg_addr), 32'(byte_idx / 4));
                end
                rx.push_back(o_tx_data);
                byte_idx++;
                prev_last = (byte_idx % 4 == 0);
            end
            prev_stall = o_tx_valid && !i_tx_ready;
            prev_data  = o_tx_data;
            if (o_done) begin
                done_count++;
                check_output("done_bytes", 32'(byte_idx), 32'(TOTAL));
                check_output("done_addr", 32'(o_dunit_reg_addr), 0);
                byte_idx = 0;
            end
        end
    end

    initial begin
        int saved_done;
        i_reset    = 1'b1;
        i_start    = 1'b0;
        i_tx_ready = 1'b1;
        i_pc       = PC_VALUE;

        @(posedge i_clk); #1;
        check_output("rst_clk_en", 32'(o_dunit_clk_en), 1);
        check_output("rst_addr", 32'(o_dunit_reg_addr), 0);
        check_output("rst_tx_data", 32'(o_tx_data), 0);
        check_output("rst_tx_valid", 32'(o_tx_valid), 0);
        check_output("rst_busy", 32'(o_busy), 0);
        check_output("rst_done", 32'(o_done), 0);
        @(posedge i_clk); #1 i_reset = 1'b0;
        repeat (2) @(posedge i_clk);

        // Full dump with the transmitter always ready
        rx.delete();
        apply_stimulus();
        wait_done(2000);
        check_output("s1_count", 32'(rx.size()), 32'(TOTAL));
        check_output("s1_done_count", 32'(done_count), 1);
        check_output("s1_byte0", 32'(rx[0]), 32'hDE);
        check_output("s1_byte3", 32'(rx[3]), 32'hEF);
        check_output("s1_byte7", 32'(rx[7]), 32'hF0);
        check_output("s1_byte126", 32'(rx[126]), 32'hBF);
        check_output("s1_byte127", 32'(rx[127]), 32'h0E);
`ifdef DUNIT_PC_DUMP_EN
        check_output("s1_pc_byte128", 32'(rx[128]), 32'h00);
        check_output("s1_pc_byte131", 32'(rx[131]), 32'h40);
`endif

        // Same stream under random back-pressure
        #1;
        rx.delete();
        rand_en = 1;
        apply_stimulus();
        wait_done(4000);
        #2;
        rand_en    = 0;
        i_tx_ready = 1'b1;
        check_output("s2_count", 32'(rx.size()), 32'(TOTAL));
        check_output("s2_done_count", 32'(done_count), 2);
        check_output("s2_byte127", 32'(rx[127]), 32'h0E);

        // Start held high through the whole dump and through DONE
        rx.delete();
        @(posedge i_clk); #1 i_start = 1'b1;
        wait_done(2000);
        #1;
        check_output("s3_idle_after_done", 32'(o_busy), 0);
        @(posedge i_clk); #1 i_start = 1'b0;
        check_output("s3_restart_busy", 32'(o_busy), 1);
        check_output("s3_first_count", 32'(rx.size()), 32'(TOTAL));
        rx.delete();
        wait_done(2000);
        check_output("s3_second_count", 32'(rx.size()), 32'(TOTAL));
        check_output("s3_done_count", 32'(done_count), 4);

        // Start pulsed mid-dump must be ignored
        rx.delete();
        saved_done = done_count;
        apply_stimulus();
        repeat (30) @(posedge i_clk);
        #1 i_start = 1'b1;
        @(posedge i_clk); #1 i_start = 1'b0;
        wait_done(2000);
        repeat (300) @(posedge i_clk);
        check_output("s4_done_once", 32'(done_count), 32'(saved_done + 1));
        check_output("s4_count", 32'(rx.size()), 32'(TOTAL));
        check_output("s4_idle", 32'(o_busy), 0);

        // Reset after 50 bytes abandons the dump
        rx.delete();
        saved_done = done_count;
        apply_stimulus();
        wait_bytes(50, 2000);
        @(posedge i_clk); #3 i_reset = 1'b1;
        #1;
        check_output("s5_tx_valid", 32'(o_tx_valid), 0);
        check_output("s5_clk_en", 32'(o_dunit_clk_en), 1);
        check_output("s5_busy", 32'(o_busy), 0);
        check_output("s5_done", 32'(o_done), 0);
        check_output("s5_addr", 32'(o_dunit_reg_addr), 0);
        check_output("s5_tx_data", 32'(o_tx_data), 0);
        @(posedge i_clk); #1 i_reset = 1'b0;
        repeat (300) @(posedge i_clk);
        check_output("s5_no_done", 32'(done_count), 32'(saved_done));
        #1;
        rx.delete();
        apply_stimulus();
        wait_done(2000);
        check_output("s5_restart_count", 32'(rx.size()), 32'(TOTAL));
        check_output("s5_restart_byte0", 32'(rx[0]), 32'hDE);
        check_output("s5_restart_byte3", 32'(rx[3]), 32'hEF);

        repeat (3) @(posedge i_clk);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
